// File: rtl/unsigned_div_arbiter.sv
// unsigned_div_arbiter
//
// Shares one multi-cycle unsigned divider between two requesters. Each
// requester owns a single pending slot. An accepted request waits in its slot
// until the arbiter hands it to the divider. When both slots are pending the
// grant alternates, so neither requester can starve the other. The divider
// result is returned to the owning requester as a one-cycle done strobe. The
// quotient/remainder outputs then hold their value until the next strobe.
//
// Optional feature (macro DIV_ARB_ZERO_BYPASS_EN):
//   When defined, a granted request whose divisor_is_zero flag is set never
//   reaches the divider. The arbiter answers it directly on the next cycle.
//   The quotient is all ones and the remainder equals the dividend.
//   When undefined, zero-divisor requests go through the divider as usual.
//
// Parameters:
//   DATA_WIDTH  operand/result width
//   CLZ_W       leading-zero count width
//
// Ports:
//   clk, rst_n                       clock, asynchronous active-low reset
//   req<p>_start                     request strobe (p = 0,1)
//   req<p>_dividend/_divisor         operands
//   req<p>_dividend_clz/_divisor_clz operand leading-zero counts
//   req<p>_divisor_is_zero           divisor-zero flag
//   req<p>_ready                     slot free, start will be accepted
//   req<p>_done                      one-cycle result strobe
//   req<p>_quotient/_remainder       results, valid while req<p>_done
//   div_start, div_dividend, div_divisor, div_dividend_clz,
//   div_divisor_clz, div_divisor_is_zero   registered divider request
//   div_done, div_quotient, div_remainder  divider response

module unsigned_div_arbiter #(
    parameter int DATA_WIDTH = 32,
    parameter int CLZ_W      = $clog2(DATA_WIDTH)
) (
    input  logic                  clk,
    input  logic                  rst_n,

    input  logic                  req0_start,
    input  logic [DATA_WIDTH-1:0] req0_dividend,
    input  logic [DATA_WIDTH-1:0] req0_divisor,
    input  logic [CLZ_W-1:0]      req0_dividend_clz,
    input  logic [CLZ_W-1:0]      req0_divisor_clz,
    input  logic                  req0_divisor_is_zero,
    output logic                  req0_ready,
    output logic                  req0_done,
    output logic [DATA_WIDTH-1:0] req0_quotient,
    output logic [DATA_WIDTH-1:0] req0_remainder,

    input  logic                  req1_start,
    input  logic [DATA_WIDTH-1:0] req1_dividend,
    input  logic [DATA_WIDTH-1:0] req1_divisor,
    input  logic [CLZ_W-1:0]      req1_dividend_clz,
    input  logic [CLZ_W-1:0]      req1_divisor_clz,
    input  logic                  req1_divisor_is_zero,
    output logic                  req1_ready,
    output logic                  req1_done,
    output logic [DATA_WIDTH-1:0] req1_quotient,
    output logic [DATA_WIDTH-1:0] req1_remainder,

    output logic                  div_start,
    output logic [DATA_WIDTH-1:0] div_dividend,
    output logic [DATA_WIDTH-1:0] div_divisor,
    output logic [CLZ_W-1:0]      div_dividend_clz,
    output logic [CLZ_W-1:0]      div_divisor_clz,
    output logic                  div_divisor_is_zero,
    input  logic                  div_done,
    input  logic [DATA_WIDTH-1:0] div_quotient,
    input  logic [DATA_WIDTH-1:0] div_remainder
);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t state, state_next;

    // Requester inputs gathered into arrays indexed by port number
    logic [1:0]                 start_in;
    logic [1:0][DATA_WIDTH-1:0] dividend_in;
    logic [1:0][DATA_WIDTH-1:0] divisor_in;
    logic [1:0][CLZ_W-1:0]      dividend_clz_in;
    logic [1:0][CLZ_W-1:0]      divisor_clz_in;
    logic [1:0]                 zero_in;

    assign start_in        = {req1_start, req0_start};
    assign dividend_in     = {req1_dividend, req0_dividend};
    assign divisor_in      = {req1_divisor, req0_divisor};
    assign dividend_clz_in = {req1_dividend_clz, req0_dividend_clz};
    assign divisor_clz_in  = {req1_divisor_clz, req0_divisor_clz};
    assign zero_in         = {req1_divisor_is_zero, req0_divisor_is_zero};

    // Pending slots
    logic [1:0]                 slot_valid;
    logic [1:0][DATA_WIDTH-1:0] slot_dividend;
    logic [1:0][DATA_WIDTH-1:0] slot_divisor;
    logic [1:0][CLZ_W-1:0]      slot_dividend_clz;
    logic [1:0][CLZ_W-1:0]      slot_divisor_clz;
    logic [1:0]                 slot_zero;

    // Result registers per port
    logic [1:0]                 done_q;
    logic [1:0][DATA_WIDTH-1:0] quotient_q;
    logic [1:0][DATA_WIDTH-1:0] remainder_q;

    logic       owner;
    logic       last_grant;
    logic       grant;
    logic       has_pending;
    logic       launch;
    logic       bypass;
    logic       result_take;
    logic [1:0] accept;
    logic [1:0] clear_mask;

    // With both slots pending the port that was not served last wins.
    // With one slot pending, the pending port wins.
    assign has_pending = |slot_valid;
    assign grant       = (&slot_valid) ? ~last_grant : slot_valid[1];
    assign accept      = start_in & ~slot_valid;

    // The divider response is ignored in the div_start cycle.
    // This prevents a stale div_done from the previous job being taken as this job's result.
    assign result_take = (state == BUSY) && !div_start && div_done;

`ifdef DIV_ARB_ZERO_BYPASS_EN
    assign bypass = (state == IDLE) && has_pending && slot_zero[grant];
`else
    assign bypass = 1'b0;
`endif

    assign launch = (state == IDLE) && has_pending && !bypass;

    // A slot is freed when its job finishes, either through the divider or
    // through the zero bypass. An accept and a clear never target the same
    // slot in one cycle: an accept needs the slot empty, a clear needs it full.
    always_comb begin
        clear_mask = 2'b00;
        if (result_take) begin
            clear_mask[owner] = 1'b1;
        end
        if (bypass) begin
            clear_mask[grant] = 1'b1;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (launch)      state_next = BUSY;
            BUSY:    if (result_take) state_next = IDLE;
            default:                  state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            slot_valid        <= '0;
            slot_dividend     <= '0;
            slot_divisor      <= '0;
            slot_dividend_clz <= '0;
            slot_divisor_clz  <= '0;
            slot_zero         <= '0;
        end else begin
            slot_valid <= (slot_valid & ~clear_mask) | accept;
            for (int p = 0; p < 2; p++) begin
                if (accept[p]) begin
                    slot_dividend[p]     <= dividend_in[p];
                    slot_divisor[p]      <= divisor_in[p];
                    slot_dividend_clz[p] <= dividend_clz_in[p];
                    slot_divisor_clz[p]  <= divisor_clz_in[p];
                    slot_zero[p]         <= zero_in[p];
                end
            end
        end
    end

    // The divider operands are loaded only at launch.
    // They therefore stay stable for the whole BUSY period.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_start           <= 1'b0;
            div_dividend        <= '0;
            div_divisor         <= '0;
            div_dividend_clz    <= '0;
            div_divisor_clz     <= '0;
            div_divisor_is_zero <= 1'b0;
            owner               <= 1'b0;
        end else begin
            div_start <= launch;
            if (launch) begin
                div_dividend        <= slot_dividend[grant];
                div_divisor         <= slot_divisor[grant];
                div_dividend_clz    <= slot_dividend_clz[grant];
                div_divisor_clz     <= slot_divisor_clz[grant];
                div_divisor_is_zero <= slot_zero[grant];
                owner               <= grant;
            end
        end
    end

    // last_grant resets to 1 so that port 0 wins the first tie.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            done_q      <= '0;
            quotient_q  <= '0;
            remainder_q <= '0;
            last_grant  <= 1'b1;
        end else begin
            done_q <= '0;
            if (result_take) begin
                done_q[owner]      <= 1'b1;
                quotient_q[owner]  <= div_quotient;
                remainder_q[owner] <= div_remainder;
                last_grant         <= owner;
            end
            if (bypass) begin
                done_q[grant]      <= 1'b1;
                quotient_q[grant]  <= '1;
                remainder_q[grant] <= slot_dividend[grant];
                last_grant         <= grant;
            end
        end
    end

    assign req0_ready     = ~slot_valid[0];
    assign req1_ready     = ~slot_valid[1];
    assign req0_done      = done_q[0];
    assign req1_done      = done_q[1];
    assign req0_quotient  = quotient_q[0];
    assign req1_quotient  = quotient_q[1];
    assign req0_remainder = remainder_q[0];
    assign req1_remainder = remainder_q[1];

endmodule

// File: tb/tb_unsigned_div_arbiter.sv
// tb_unsigned_div_arbiter
//
// Directed bench for unsigned_div_arbiter. It includes a behavioural divider.
// The divider answers each div_start after a programmable number of cycles.
// Expected results are hand-computed constants.
// Honours DIV_ARB_ZERO_BYPASS_EN in the zero-divisor step.

module tb_unsigned_div_arbiter;

    localparam int DW = 32;
    localparam int CW = $clog2(DW);

    logic          clk;
    logic          rst_n;

    logic          req0_start, req1_start;
    logic [DW-1:0] req0_dividend, req0_divisor, req1_dividend, req1_divisor;
    logic [CW-1:0] req0_dividend_clz, req0_divisor_clz;
    logic [CW-1:0] req1_dividend_clz, req1_divisor_clz;
    logic          req0_divisor_is_zero, req1_divisor_is_zero;
    logic          req0_ready, req1_ready, req0_done, req1_done;
    logic [DW-1:0] req0_quotient, req0_remainder, req1_quotient, req1_remainder;

    logic          div_start;
    logic [DW-1:0] div_dividend, div_divisor;
    logic [CW-1:0] div_dividend_clz, div_divisor_clz;
    logic          div_divisor_is_zero;
    logic          div_done;
    logic [DW-1:0] div_quotient, div_remainder;

    int checks;
    int failures;
    int lat;
    int div_start_count;
    int done_cnt0;
    int done_cnt1;

    unsigned_div_arbiter #(.DATA_WIDTH(DW), .CLZ_W(CW)) dut (
        .clk                  (clk),
        .rst_n                (rst_n),
        .req0_start           (req0_start),
        .req0_dividend        (req0_dividend),
        .req0_divisor         (req0_divisor),
        .req0_dividend_clz    (req0_dividend_clz),
        .req0_divisor_clz     (req0_divisor_clz),
        .req0_divisor_is_zero (req0_divisor_is_zero),
        .req0_ready           (req0_ready),
        .req0_done            (req0_done),
        .req0_quotient        (req0_quotient),
        .req0_remainder       (req0_remainder),
        .req1_start           (req1_start),
        .req1_dividend        (req1_dividend),
        .req1_divisor         (req1_divisor),
        .req1_dividend_clz    (req1_dividend_clz),
        .req1_divisor_clz     (req1_divisor_clz),
        .req1_divisor_is_zero (req1_divisor_is_zero),
        .req1_ready           (req1_ready),
        .req1_done            (req1_done),
        .req1_quotient        (req1_quotient),
        .req1_remainder       (req1_remainder),
        .div_start            (div_start),
        .div_dividend         (div_dividend),
        .div_divisor          (div_divisor),
        .div_dividend_clz     (div_dividend_clz),
        .div_divisor_clz      (div_divisor_clz),
        .div_divisor_is_zero  (div_divisor_is_zero),
        .div_done             (div_done),
        .div_quotient         (div_quotient),
        .div_remainder        (div_remainder)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Done strobes are counted mid-cycle to catch spurious or repeated pulses
    always @(negedge clk) begin
        if (req0_done) done_cnt0++;
        if (req1_done) done_cnt1++;
    end

    // Behavioural divider: answers each div_start after lat cycles
    initial begin : divider_model
        logic [DW-1:0] a, b;
        div_done        = 1'b0;
        div_quotient    = '0;
        div_remainder   = '0;
        div_start_count = 0;
        forever begin
            @(posedge clk);
            #1;
            if (div_start === 1'b1) begin
                div_start_count++;
                a = div_dividend;
                b = div_divisor;
                repeat (lat) @(posedge clk);
                #1;
                div_done = 1'b1;
                if (b == 0) begin
                    div_quotient  = '1;
                    div_remainder = a;
                end else begin
                    div_quotient  = a / b;
                    div_remainder = a % b;
                end
                @(posedge clk);
                #1;
                div_done = 1'b0;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [DW-1:0] observed,
                               input logic [DW-1:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            failures++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input int port, input logic start,
                                 input logic [DW-1:0] dividend, input logic [DW-1:0] divisor,
                                 input logic [CW-1:0] dclz, input logic [CW-1:0] vclz,
                                 input logic zero);
        if (port == 0) begin
            req0_start = start; req0_dividend = dividend; req0_divisor = divisor;
            req0_dividend_clz = dclz; req0_divisor_clz = vclz; req0_divisor_is_zero = zero;
        end else begin
            req1_start = start; req1_dividend = dividend; req1_divisor = divisor;
            req1_dividend_clz = dclz; req1_divisor_clz = vclz; req1_divisor_is_zero = zero;
        end
    endtask

    // Steps cycles until the port's done strobe is seen or the budget expires
    task automatic waitDone(input int port, input int budget, output int cycles);
        logic seen;
        seen   = 1'b0;
        cycles = 0;
        while (!seen && cycles < budget) begin
            tick();
            cycles++;
            seen = (port == 0) ? req0_done : req1_done;
        end
        checkOutput($sformatf("done_seen_p%0d", port), {31'd0, seen}, 32'd1);
    endtask

    initial begin : stimulus
        int cyc;
        int base_starts;
        int base0;
        int base1;
        checks   = 0;
        failures = 0;
        lat      = 5;
        done_cnt0 = 0;
        done_cnt1 = 0;
        rst_n = 1'b0;
        applyStimulus(0, 1'b0, '0, '0, '0, '0, 1'b0);
        applyStimulus(1, 1'b0, '0, '0, '0, '0, 1'b0);

        // Reset state
        #3;
        checkOutput("rst_ready0", {31'd0, req0_ready}, 32'd1);
        checkOutput("rst_ready1", {31'd0, req1_ready}, 32'd1);
        checkOutput("rst_done0", {31'd0, req0_done}, 32'd0);
        checkOutput("rst_div_start", {31'd0, div_start}, 32'd0);
        checkOutput("rst_q0", req0_quotient, 32'd0);
        checkOutput("rst_div_dividend", div_dividend, 32'd0);
        tick();
        tick();
        rst_n = 1'b1;
        tick();

        // Single request 100/7, divider answers 5 cycles after div_start
        applyStimulus(0, 1'b1, 32'd100, 32'd7, 5'd25, 5'd29, 1'b0);
        tick();
        applyStimulus(0, 1'b0, 32'd100, 32'd7, 5'd25, 5'd29, 1'b0);
        checkOutput("t1_ready0_low", {31'd0, req0_ready}, 32'd0);
        checkOutput("t1_div_start_early", {31'd0, div_start}, 32'd0);
        tick();
        checkOutput("t1_div_start", {31'd0, div_start}, 32'd1);
        checkOutput("t1_div_dividend", div_dividend, 32'd100);
        checkOutput("t1_div_divisor", div_divisor, 32'd7);
        checkOutput("t1_div_dividend_clz", {27'd0, div_dividend_clz}, 32'd25);
        checkOutput("t1_div_divisor_clz", {27'd0, div_divisor_clz}, 32'd29);
        waitDone(0, 20, cyc);
        checkOutput("t1_latency", cyc, 32'd6);
        checkOutput("t1_q", req0_quotient, 32'd14);
        checkOutput("t1_r", req0_remainder, 32'd2);
        checkOutput("t1_ready0_in_done", {31'd0, req0_ready}, 32'd1);
        tick();
        checkOutput("t1_done_one_cycle", {31'd0, req0_done}, 32'd0);
        checkOutput("t1_q_hold", req0_quotient, 32'd14);
        checkOutput("t1_done1_never", done_cnt1, 32'd0);
        checkOutput("t1_div_starts", div_start_count, 32'd1);

        // Simultaneous starts after reset: port 0 first, then port 1
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        lat = 3;
        base_starts = div_start_count;
        base0 = done_cnt0;
        base1 = done_cnt1;
        applyStimulus(0, 1'b1, 32'd50, 32'd5, 5'd26, 5'd29, 1'b0);
        applyStimulus(1, 1'b1, 32'd9, 32'd4, 5'd28, 5'd29, 1'b0);
        tick();
        applyStimulus(0, 1'b0, 32'd0, 32'd0, 5'd0, 5'd0, 1'b0);
        applyStimulus(1, 1'b0, 32'd0, 32'd0, 5'd0, 5'd0, 1'b0);
        waitDone(0, 20, cyc);
        checkOutput("t2_q0", req0_quotient, 32'd10);
        checkOutput("t2_r0", req0_remainder, 32'd0);
        checkOutput("t2_p1_not_first", done_cnt1 - base1, 32'd0);
        waitDone(1, 20, cyc);
        checkOutput("t2_q1", req1_quotient, 32'd2);
        checkOutput("t2_r1", req1_remainder, 32'd1);
        checkOutput("t2_div_starts", div_start_count - base_starts, 32'd2);
        tick();
        checkOutput("t2_done_counts", (done_cnt0 - base0) + (done_cnt1 - base1), 32'd2);

        // Round robin: port 1 waits during port 0 job, port 0 restarts in its done cycle
        lat = 4;
        base0 = done_cnt0;
        base1 = done_cnt1;
        applyStimulus(0, 1'b1, 32'd20, 32'd3, 5'd27, 5'd30, 1'b0);
        tick();
        applyStimulus(0, 1'b0, 32'd0, 32'd0, 5'd0, 5'd0, 1'b0);
        tick();
        applyStimulus(1, 1'b1, 32'd30, 32'd4, 5'd27, 5'd29, 1'b0);
        tick();
        applyStimulus(1, 1'b0, 32'd0, 32'd0, 5'd0, 5'd0, 1'b0);
        checkOutput("t3_ready1_low", {31'd0, req1_ready}, 32'd0);
        waitDone(0, 20, cyc);
        checkOutput("t3_q0a", req0_quotient, 32'd6);
        checkOutput("t3_r0a", req0_remainder, 32'd2);
        checkOutput("t3_ready0_in_done", {31'd0, req0_ready}, 32'd1);
        applyStimulus(0, 1'b1, 32'd40, 32'd8, 5'd26, 5'd28, 1'b0);
        tick();
        applyStimulus(0, 1'b0, 32'd0, 32'd0, 5'd0, 5'd0, 1'b0);
        checkOutput("t3_restart_accepted", {31'd0, req0_ready}, 32'd0);
        checkOutput("t3_grant1_start", {31'd0, div_start}, 32'd1);
        checkOutput("t3_grant1_dividend", div_dividend, 32'd30);
        waitDone(1, 20, cyc);
        checkOutput("t3_q1", req1_quotient, 32'd7);
        checkOutput("t3_r1", req1_remainder, 32'd2);
        checkOutput("t3_p0_waits", done_cnt0 - base0, 32'd1);
        waitDone(0, 20, cyc);
        checkOutput("t3_q0b", req0_quotient, 32'd5);
        checkOutput("t3_r0b", req0_remainder, 32'd0);
        checkOutput("t3_q1_hold", req1_quotient, 32'd7);

        // Start while not ready is ignored
        tick();
        base0 = done_cnt0;
        base_starts = div_start_count;
        applyStimulus(0, 1'b1, 32'd100, 32'd10, 5'd25, 5'd28, 1'b0);
        tick();
        checkOutput("t4_not_ready", {31'd0, req0_ready}, 32'd0);
        applyStimulus(0, 1'b1, 32'd1, 32'd1, 5'd31, 5'd31, 1'b0);
        tick();
        applyStimulus(0, 1'b0, 32'd0, 32'd0, 5'd0, 5'd0, 1'b0);
        waitDone(0, 20, cyc);
        checkOutput("t4_q", req0_quotient, 32'd10);
        checkOutput("t4_r", req0_remainder, 32'd0);
        repeat (12) tick();
        checkOutput("t4_single_done", done_cnt0 - base0, 32'd1);
        checkOutput("t4_single_div_start", div_start_count - base_starts, 32'd1);
        checkOutput("t4_q_hold", req0_quotient, 32'd10);

        // Zero divisor on port 1
        base1 = done_cnt1;
        base_starts = div_start_count;
        applyStimulus(1, 1'b1, 32'h1234, 32'd0, 5'd19, 5'd0, 1'b1);
        tick();
        applyStimulus(1, 1'b0, 32'd0, 32'd0, 5'd0, 5'd0, 1'b0);
`ifdef DIV_ARB_ZERO_BYPASS_EN
        tick();
        checkOutput("t5_bypass_done", {31'd0, req1_done}, 32'd1);
        checkOutput("t5_bypass_q", req1_quotient, 32'hFFFF_FFFF);
        checkOutput("t5_bypass_r", req1_remainder, 32'h1234);
        checkOutput("t5_bypass_no_start", {31'd0, div_start}, 32'd0);
        checkOutput("t5_bypass_ready", {31'd0, req1_ready}, 32'd1);
        repeat (8) tick();
        checkOutput("t5_bypass_starts", div_start_count - base_starts, 32'd0);
`else
        waitDone(1, 20, cyc);
        checkOutput("t5_q", req1_quotient, 32'hFFFF_FFFF);
        checkOutput("t5_r", req1_remainder, 32'h1234);
        checkOutput("t5_div_started", div_start_count - base_starts, 32'd1);
        repeat (4) tick();
`endif
        checkOutput("t5_single_done", done_cnt1 - base1, 32'd1);

        // Reset during BUSY: no done afterwards even though div_done arrives
        lat = 5;
        base0 = done_cnt0;
        base1 = done_cnt1;
        applyStimulus(0, 1'b1, 32'd77, 32'd7, 5'd25, 5'd29, 1'b0);
        tick();
        applyStimulus(0, 1'b0, 32'd0, 32'd0, 5'd0, 5'd0, 1'b0);
        tick();
        checkOutput("t6_busy_start", {31'd0, div_start}, 32'd1);
        base_starts = div_start_count;
        tick();
        rst_n = 1'b0;
        #1;
        checkOutput("t6_rst_ready0", {31'd0, req0_ready}, 32'd1);
        checkOutput("t6_rst_q0", req0_quotient, 32'd0);
        tick();
        rst_n = 1'b1;
        repeat (10) tick();
        checkOutput("t6_no_done0", done_cnt0 - base0, 32'd0);
        checkOutput("t6_no_done1", done_cnt1 - base1, 32'd0);
        checkOutput("t6_ready0", {31'd0, req0_ready}, 32'd1);
        checkOutput("t6_idle_no_start", div_start_count - base_starts, 32'd0);
        checkOutput("t6_q0_cleared", req0_quotient, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/unsigned_div_arbiter.md
UNSIGNED_DIV_ARBITER -- requirements
Module: unsigned_div_arbiter

Interface
REQ-001 SHALL have parameter: DATA_WIDTH, 32, operand/result width.
REQ-002 SHALL have parameter: CLZ_W, $clog2(DATA_WIDTH), leading-zero count width.
REQ-003 SHALL have port: clk  in  1  single clock, all state on rising edge.
REQ-004 SHALL have port: rst_n  in  1  reset, asynchronous, active-low.
REQ-005 SHALL have ports, per requester p in {0,1}: req<p>_start  in  1  request strobe.
REQ-006 SHALL have ports: req<p>_dividend, req<p>_divisor  in  DATA_WIDTH  operands.
REQ-007 SHALL have ports: req<p>_dividend_clz, req<p>_divisor_clz  in  CLZ_W  operand leading-zero counts.
REQ-008 SHALL have port: req<p>_divisor_is_zero  in  1  divisor-zero flag.
REQ-009 SHALL have ports: req<p>_ready  out  1  slot free; req<p>_done  out  1  one-cycle result strobe.
REQ-010 SHALL have ports: req<p>_quotient, req<p>_remainder  out  DATA_WIDTH  results, valid while req<p>_done.
REQ-011 SHALL have divider-side outputs div_start (1), div_dividend, div_divisor (DATA_WIDTH), div_dividend_clz, div_divisor_clz (CLZ_W), div_divisor_is_zero (1).
REQ-012 SHALL have divider-side inputs div_done (1), div_quotient, div_remainder (DATA_WIDTH).

Function
REQ-013 SHALL hold one pending slot per port; req<p>_ready = slot empty.
REQ-014 SHALL latch all req<p> operands and set the slot at the edge where req<p>_start and req<p>_ready are both 1; start while not ready SHALL be ignored.
REQ-015 SHALL implement states IDLE and BUSY.
REQ-016 In IDLE with >=1 slot set, SHALL select a port, load div_* operand registers from its slot, record the owner, and go BUSY at that edge.
REQ-017 Selection SHALL be round-robin: one pending -> that port; both pending -> the port other than last_grant.
REQ-018 div_start SHALL be registered and 1 for exactly the first BUSY cycle; div_* operands SHALL be stable throughout BUSY.
REQ-019 div_done SHALL be ignored in IDLE and in the div_start cycle.
REQ-020 In BUSY with div_done=1, SHALL at that edge register div_quotient/div_remainder to the owner's outputs, assert the owner's done for the next cycle only, clear its slot, set last_grant=owner, and go IDLE.
REQ-021 Latency: start accepted at edge N -> div_start in cycle N+1 -> done one cycle after the div_done cycle.
REQ-022 A port SHALL be ready in its done cycle; a start in that cycle is accepted.
REQ-023 The non-owner's start during BUSY SHALL be accepted if its slot is empty and served in the next IDLE cycle.
REQ-024 The non-selected port's done SHALL be 0; each port's result outputs SHALL hold their last values between strobes.

Reset
REQ-025 rst_n=0 SHALL immediately: state IDLE, slots empty, ready=1, done=0, div_start=0, all data outputs 0, last_grant=1 (port 0 wins first tie).
REQ-026 Reset mid-operation SHALL discard all pending and in-flight requests; no done SHALL follow; div_done SHALL be ignored until a new BUSY.

Configuration
REQ-027 Macro DIV_ARB_ZERO_BYPASS_EN defined: a selected slot with divisor_is_zero=1 SHALL NOT enter BUSY or pulse div_start; next cycle: owner done=1, quotient all ones, remainder = dividend; slot cleared, last_grant updated, state stays IDLE.
REQ-028 Macro undefined: zero-divisor requests SHALL go through the divider like any other.

Verification
REQ-029 Port 0 start, 100/7; divider done 5 cycles after div_start -> div_start 1 cycle after accept; req0_done with quotient 14, remainder 2; req1_done stays 0.
REQ-030 Both ports start same cycle after reset (0: 50/5, 1: 9/4) -> port 0 served first (10 r0), then port 1 (2 r1); div_start twice.
REQ-031 Port 0 busy, port 1 start, then port 0 restarts in its done cycle -> port 1 granted next (round-robin), then port 0.
REQ-032 req0_start while req0_ready=0, operands 1/1 -> ignored; only the original result returns.
REQ-033 With DIV_ARB_ZERO_BYPASS_EN, 0x1234/0 -> no div_start; req done 2 cycles after start, quotient 0xFFFFFFFF, remainder 0x1234; without macro -> div_start issued.
REQ-034 rst_n low during BUSY, div_done pulses after release -> no done, ready=1, state IDLE.
